// File: rtl/tdc_multi_capture.sv
// rtl/tdc_multi_capture.sv - multi-channel coarse/fine TDC capture controller with record FIFO
module tdc_multi_capture #(
    parameter int N_DELAY    = 32,
    parameter int N_CH       = 2,
    parameter int COARSE_W   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH*N_DELAY-1:0] therm,
    input  logic [1:0]              byte_sel,
    input  logic                    rd_en,
    output logic [7:0]              dout,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                arm_q, start_q;
    logic [N_CH-1:0]     stop_q;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [N_CH-1:0]     captured_q, captured_d;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [31:0]         pend_rec_q [N_CH];
    logic [31:0]         pend_rec_d [N_CH];
    logic                overflow_q, overflow_d;
    logic [31:0]         fifo_q [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;

    logic                arm_edge, start_edge;
    logic [N_CH-1:0]     stop_edge;
    logic [N_CH-1:0]     sel_oh;
    logic [31:0]         sel_rec, head;
    logic                wr_req, do_wr, do_rd, drop;

    // Fine time is the number of set taps; clamp so it always fits the 8-bit field.
    function automatic logic [7:0] popcount(input logic [N_DELAY-1:0] v);
        int cnt;
        cnt = 0;
        for (int b = 0; b < N_DELAY; b++) cnt += int'(v[b]);
        if (cnt > 255) cnt = 255;
        return 8'(cnt);
    endfunction

    function automatic logic [31:0] make_rec(input logic tmo, input int ch,
                                             input logic [COARSE_W-1:0] c, input logic [7:0] f);
        logic [15:0] c16;
        c16 = '0;
        c16[COARSE_W-1:0] = c;
        return {tmo, 1'b0, 6'(ch), c16, f};
    endfunction

    assign arm_edge   = arm & ~arm_q;
    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = fifo_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE);

    // Pick the lowest-index pending record for this cycle's FIFO write.
    always_comb begin
        sel_oh  = '0;
        sel_rec = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_rec   = pend_rec_q[i];
            end
        end
    end

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    always_comb begin
        wr_req = |pending_q;
        do_rd  = rd_en & ~empty;
        do_wr  = wr_req & (~full | do_rd);
        drop   = wr_req & full & ~do_rd;
    end

    // Byte view of the head record; reads as zero when nothing is queued.
    always_comb begin
        dout = head[8*byte_sel +: 8];
        if (empty) dout = 8'h00;
    end

    // Run FSM: arming, coarse counting, per-channel capture and timeout fill.
    always_comb begin
        state_d    = state_q;
        coarse_d   = coarse_q;
        captured_d = captured_q;
        pending_d  = pending_q & ~sel_oh;
        pend_rec_d = pend_rec_q;
        overflow_d = overflow_q | drop;
        case (state_q)
            S_IDLE: begin
                if (arm_edge) begin
                    state_d    = S_ARMED;
                    overflow_d = 1'b0;
                    captured_d = '0;
                end
            end
            S_ARMED: begin
                if (start_edge) begin
                    state_d  = S_RUN;
                    coarse_d = '0;
                end
            end
            S_RUN: begin
                coarse_d = (coarse_q == '1) ? coarse_q : coarse_q + COARSE_W'(1);
                for (int i = 0; i < N_CH; i++) begin
                    if (stop_edge[i] && !captured_q[i]) begin
                        captured_d[i] = 1'b1;
                        pending_d[i]  = 1'b1;
                        pend_rec_d[i] = make_rec(1'b0, i, coarse_q,
                                                 popcount(therm[i*N_DELAY +: N_DELAY]));
                    end
                end
                if (coarse_q == '1) begin
                    // Channels still open at the last count get a timeout record.
                    for (int i = 0; i < N_CH; i++) begin
                        if (!captured_d[i]) begin
                            captured_d[i] = 1'b1;
                            pending_d[i]  = 1'b1;
                            pend_rec_d[i] = make_rec(1'b1, i, '1, 8'h00);
                        end
                    end
                    state_d = S_DRAIN;
                end else if (&captured_d) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pending_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, edge detectors and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            coarse_q   <= '0;
            captured_q <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            arm_q      <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            coarse_q   <= coarse_d;
            captured_q <= captured_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            arm_q      <= arm;
            start_q    <= start;
            stop_q     <= stop;
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Record storage; validity is carried by pending_q and the FIFO pointers.
    always_ff @(posedge clk) begin
        pend_rec_q <= pend_rec_d;
        if (do_wr) fifo_q[wr_ptr_q[AW-1:0]] <= sel_rec;
    end

endmodule

// File: tb/tb_tdc_multi_capture.sv
// tb/tb_tdc_multi_capture.sv - scoreboard bench for tdc_multi_capture
module tb_tdc_multi_capture;
    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        start;
    logic [1:0]  stop;
    logic [63:0] therm;
    logic [1:0]  byte_sel;
    logic        rd_en;
    logic [7:0]  dout;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        busy;

    logic        mon_en;
    logic [1:0]  mon_sel, stim_sel;
    logic        mon_rd, stim_rd;
    logic [31:0] sb_q[$];
    int          checks;
    int          errors;

    assign byte_sel = mon_en ? mon_sel : stim_sel;
    assign rd_en    = mon_en ? mon_rd : stim_rd;

    tdc_multi_capture #(
        .N_DELAY(32), .N_CH(2), .COARSE_W(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .start(start), .stop(stop),
        .therm(therm), .byte_sel(byte_sel), .rd_en(rd_en), .dout(dout),
        .empty(empty), .full(full), .overflow(overflow), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Monitor: whenever a record is at the head, read its four bytes, compare and pop.
    initial begin
        logic [31:0] got, exp;
        mon_sel = 2'd0;
        mon_rd  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !empty) begin
                got = '0;
                for (int b = 0; b < 4; b++) begin
                    mon_sel = 2'(b);
                    #1;
                    got[8*b +: 8] = dout;
                end
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record got=%08h exp=none", got);
                end else begin
                    exp = sb_q.pop_front();
                    for (int b = 0; b < 4; b++)
                        check($sformatf("rec_byte%0d", b), 32'(got[8*b +: 8]), 32'(exp[8*b +: 8]));
                end
                mon_rd = 1'b1;
                @(posedge clk);
                #1;
                mon_rd = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        arm = 1'b1;
        tick();
        arm   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_head(output logic [31:0] w);
        w = '0;
        for (int b = 0; b < 4; b++) begin
            stim_sel = 2'(b);
            #1;
            w[8*b +: 8] = dout;
        end
    endtask

    task automatic wait_drained(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && empty && !busy) && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic wait_not_busy(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic dual_stop_run(input int c, input logic [31:0] t0, input logic [31:0] t1);
        run_start();
        repeat (c) tick();
        therm = {t1, t0};
        stop  = 2'b11;
        tick();
        stop = 2'b00;
        wait_not_busy("dual_run_end", 20);
    endtask

    initial begin
        logic [31:0] w, exp;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        arm      = 1'b0;
        start    = 1'b0;
        stop     = 2'b00;
        therm    = '0;
        stim_sel = 2'd0;
        stim_rd  = 1'b0;
        mon_en   = 1'b0;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single stop on ch0 at coarse 5; ch1 then times out at coarse 15
        mon_en = 1'b1;
        run_start();
        repeat (5) tick();
        therm = {32'h0, 32'h0000FFFF};
        stop  = 2'b01;
        sb_q.push_back(32'h0000_0510);
        sb_q.push_back(32'h8100_0F00);
        tick();
        stop = 2'b00;
        @(negedge clk);
        check("lat_t1_empty", 32'(empty), 32'd1);
        check("lat_t1_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("lat_t2_empty", 32'(empty), 32'd0);
        wait_drained("t1_drain", 60);

        // Simultaneous stops at coarse 3, serialised ch0 then ch1
        run_start();
        repeat (3) tick();
        therm = {32'h0000_00FF, 32'h0000_0001};
        stop  = 2'b11;
        sb_q.push_back(32'h0000_0301);
        sb_q.push_back(32'h0100_0308);
        tick();
        stop = 2'b00;
        @(negedge clk);
        check("sim_t1_busy", 32'(busy), 32'd1);
        check("sim_t1_empty", 32'(empty), 32'd1);
        tick();
        @(negedge clk);
        check("sim_t2_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("sim_t3_busy", 32'(busy), 32'd0);
        wait_drained("t2_drain", 30);

        // Only ch1 stops at coarse 7; ch0 times out after 15 RUN cycles
        run_start();
        repeat (7) tick();
        therm = {32'hFFFF_FFFF, 32'h0};
        stop  = 2'b10;
        sb_q.push_back(32'h0100_0720);
        sb_q.push_back(32'h8000_0F00);
        tick();
        stop = 2'b00;
        repeat (8) tick();
        @(negedge clk);
        check("tmo_c16_empty", 32'(empty), 32'd1);
        check("tmo_c16_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("tmo_c17_empty", 32'(empty), 32'd0);
        check("tmo_c17_busy", 32'(busy), 32'd0);
        wait_drained("t3_drain", 30);

        // Three runs without reads: four records kept, two dropped
        mon_en = 1'b0;
        dual_stop_run(1, 32'h0000_0003, 32'h0000_0007);
        sb_q.push_back(32'h0000_0102);
        sb_q.push_back(32'h0100_0103);
        dual_stop_run(2, 32'h0000_000F, 32'h0000_001F);
        sb_q.push_back(32'h0000_0204);
        sb_q.push_back(32'h0100_0205);
        @(negedge clk);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        tick();
        dual_stop_run(3, 32'h0000_0001, 32'h0000_0001);
        @(negedge clk);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_empty", 32'(empty), 32'd0);
        tick();

        // Re-arm clears overflow and keeps contents; write and read while full
        run_start();
        @(negedge clk);
        check("rearm_overflow", 32'(overflow), 32'd0);
        check("rearm_full", 32'(full), 32'd1);
        tick();
        tick();
        therm = {32'h0, 32'h0000_003F};
        stop  = 2'b01;
        sb_q.push_back(32'h0000_0206);
        tick();
        stop    = 2'b00;
        stim_rd = 1'b1;
        @(negedge clk);
        read_head(w);
        exp = sb_q.pop_front();
        check("rw_head_before", w, exp);
        check("rw_full_before", 32'(full), 32'd1);
        tick();
        stim_rd = 1'b0;
        @(negedge clk);
        check("rw_full_after", 32'(full), 32'd1);
        check("rw_overflow_after", 32'(overflow), 32'd0);
        read_head(w);
        check("rw_head_after", w, 32'h0100_0103);
        tick();
        mon_en = 1'b1;
        tick();
        therm = {32'h0000_0001, 32'h0};
        stop  = 2'b10;
        sb_q.push_back(32'h0100_0601);
        tick();
        stop = 2'b00;
        wait_drained("t5_drain", 60);

        // Reset mid-RUN with one pending record
        run_start();
        repeat (3) tick();
        therm = {32'h0, 32'h0000_0003};
        stop  = 2'b01;
        tick();
        stop  = 2'b00;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        check("mrst_full", 32'(full), 32'd0);
        tick();
        therm = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        stop  = 2'b11;
        tick();
        stop = 2'b00;
        repeat (4) tick();
        @(negedge clk);
        check("noarm_busy", 32'(busy), 32'd0);
        check("noarm_empty", 32'(empty), 32'd1);
        check("noarm_sb", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_multi_capture.md
Name: tdc_multi_capture

Overview:
- Parametrised multi-channel coarse/fine TDC capture controller. Successor to the single-channel 32-tap TDC top.
- Each channel's fine time is the population count of its delay-line thermometer code. Coarse time comes from a cycle counter started by `start`.
- Timestamp records are queued in a shared FIFO and read out one byte at a time through a 4:1 byte mux. Sits between the `tdc_delay` instances and the uo_out pins.

Parameters:
- N_DELAY, 32: taps per delay line; fine field = popcount, max 255.
- N_CH, 2: stop channels, 1..64.
- COARSE_W, 8: coarse counter width, 1..16.
- FIFO_DEPTH, 4: record FIFO entries; power of two, 2 or more.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset (1 = reset); pin name kept for top-level compatibility.
- arm  input  1  level, sampled per cycle; a 0->1 edge arms a run.
- start  input  1  level, clk-synchronous; a 0->1 edge starts the coarse count.
- stop  input  N_CH  per-channel levels, clk-synchronous; a 0->1 edge captures that channel.
- therm  input  N_CH*N_DELAY  thermometer codes; channel i occupies bits [i*N_DELAY +: N_DELAY].
- byte_sel  input  2  selects a byte of the FIFO head record.
- rd_en  input  1  pops the FIFO head when not empty.
- dout  output  8  selected byte of the head record.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- overflow  output  1  sticky flag: a record was dropped.
- busy  output  1  run in progress or records still pending.

Behaviour:
- Edge detection: arm, start and stop are each registered once. An edge is "now=1, previous=0".
- Record format, 32 bits:
  - [31] timeout
  - [30] 0
  - [29:24] channel index
  - [23:8] coarse count, zero-extended
  - [7:0] fine popcount, zero-extended
- dout = head[8*byte_sel +: 8], combinational. dout = 0 when empty.
- FSM states:
  - IDLE -> ARMED on an arm edge. That edge also clears overflow and the captured[] flags. An arm edge outside IDLE is ignored.
  - ARMED -> RUN on a start edge. coarse = 0 in the first RUN cycle, then +1 per cycle, saturating at all-ones. Stop edges in ARMED are ignored.
  - RUN: a stop edge on channel i with captured[i] = 0 latches {i, coarse, popcount(therm_i)} into pending[i] and sets captured[i]. The therm value is taken in the same cycle as the edge. Repeat edges on a captured channel are ignored.
  - RUN -> DRAIN when all captured[] are set.
  - RUN -> DRAIN on timeout, i.e. coarse = all-ones in a cycle. Every uncaptured channel is then given a pending record with timeout = 1, coarse = all-ones, fine = 0.
  - DRAIN -> IDLE once no pending records remain.
- Pending drain:
  - One record per cycle is written to the FIFO, lowest pending index first.
  - A record is written the cycle after it was latched.
  - Simultaneous stops are serialised in index order.
- FIFO write when full: the record is dropped, its pending slot is cleared and overflow is set.
- FIFO read and write in the same cycle are both performed, including when full. In that case nothing is dropped and overflow is not set.
- rd_en while empty is ignored.
- busy = 1 in ARMED, RUN and DRAIN.
- Reset values, any cycle including mid-run:
  - FSM IDLE, coarse 0, captured 0, pending 0.
  - FIFO empty: empty = 1, full = 0, dout = 0.
  - overflow 0, busy 0.
  - Edge-detect registers 0.
- Latency: a stop edge seen in cycle t with a 1-deep backlog makes the record visible at the head with empty = 0 at cycle t+2.

Test Plan:
- Reset, arm edge, start edge, then ch0 stop edge 5 cycles after start with therm0 = 0x0000FFFF -> one record 0x0000_0510. byte_sel 0..3 -> dout 0x10, 0x05, 0x00, 0x00.
- N_CH = 2, ch0 and ch1 stop edges in the same cycle at coarse 3, therm1 = 0x000000FF -> ch0 record then ch1 record 0x0100_0308 on successive cycles. busy falls after the second write.
- Only ch1 stops, at coarse 7 with therm1 = all-ones. COARSE_W = 4 -> ch1 record 0x0100_0720. ch0 timeout record 0x8000_0F00 appears after 15 RUN cycles.
- FIFO_DEPTH = 4 with no reads over 3 runs of 2 channels -> full after 4 records, overflow = 1, 2 records dropped. The next arm edge clears overflow, and FIFO contents are retained.
- FIFO full, and a write and rd_en occur in the same cycle -> count stays 4, overflow stays 0, head advances.
- rst_n = 1 mid-RUN with 1 pending record -> the next cycle shows empty = 1, busy = 0, dout = 0, and stop edges are ignored until re-armed.
